// File: rtl/accum_delta_decoder.sv
// Inverts a modulo-2^WIDTH running-sum stream back into per-sample increments,
// with valid/ready on both sides and a 2-entry output buffer for backpressure.
module accum_delta_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Sync,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic [WIDTH-1:0]     i_Data,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic [WIDTH-1:0]     o_Incr,
  output logic [CNT_WIDTH-1:0] o_Count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               r_State, w_State;
  logic [WIDTH-1:0]     r_Prev, w_Prev;
  logic [WIDTH-1:0]     r_Head, w_Head;
  logic [WIDTH-1:0]     r_Tail, w_Tail;
  logic [CNT_WIDTH-1:0] r_Count, w_Count;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] delta;

  // Outputs depend on registered state only.
  assign o_Ready = (r_State != StFull);
  assign o_Valid = (r_State != StEmpty);
  assign o_Incr  = (r_State == StEmpty) ? '0 : r_Head;
  assign o_Count = r_Count;

  // Sync wins over both handshakes in the same cycle.
  assign accept = i_Valid && o_Ready && !i_Sync;
  assign pop    = o_Valid && i_Ready && !i_Sync;
  assign delta  = i_Data - r_Prev;

  always_comb begin
    w_State = r_State;
    w_Prev  = r_Prev;
    w_Head  = r_Head;
    w_Tail  = r_Tail;
    w_Count = r_Count;

    if (i_Sync) begin
      w_State = StEmpty;
      w_Prev  = '0;
    end else begin
      if (accept) begin
        w_Prev = i_Data;
      end
      if (pop) begin
        w_Count = r_Count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      unique case (r_State)
        StEmpty: begin
          if (accept) begin
            w_Head  = delta;
            w_State = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            w_Head = delta;
          end else if (accept) begin
            w_Tail  = delta;
            w_State = StFull;
          end else if (pop) begin
            w_State = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            w_Head  = r_Tail;
            w_State = StOne;
          end
        end
        default: w_State = StEmpty;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State <= StEmpty;
      r_Prev  <= '0;
      r_Head  <= '0;
      r_Tail  <= '0;
      r_Count <= '0;
    end else begin
      r_State <= w_State;
      r_Prev  <= w_Prev;
      r_Head  <= w_Head;
      r_Tail  <= w_Tail;
      r_Count <= w_Count;
    end
  end

endmodule
